// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
// Port 0 is the line-buffer fill side, port 1 is the drain side.
package sp_ram_arb_pkg;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    // Wide enough for the largest legal MAX_BURST (15).
    localparam int BURST_CNT_W = 4;

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/sp_ram_arb_rsp_pipe.sv
// Read-tag shift register. It follows accepted reads through the RAM latency and
// routes ram_rd_data to the port that issued each read.
module sp_ram_arb_rsp_pipe
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  port_idx_t                  push_port,
    input  logic [DATA_WIDTH-1:0]      ram_rd_data,
    output logic [1:0]                 rsp_valid,
    output logic [1:0][DATA_WIDTH-1:0] rsp_rdata
);

    logic      [RD_LATENCY:1] vld_pipe;
    port_idx_t [RD_LATENCY:1] port_pipe;
    logic                     exit_vld;
    port_idx_t                exit_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            vld_pipe[1]  <= push_vld;
            port_pipe[1] <= push_port;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                port_pipe[i] <= port_pipe[i-1];
            end
        end
    end

    // A tag leaving the pipe while rst is high belongs to a discarded read.
    assign exit_vld  = vld_pipe[RD_LATENCY] & ~rst;
    assign exit_port = port_pipe[RD_LATENCY];

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] rdata_q;

        assign rsp_valid[p] = exit_vld & (exit_port == port_idx_t'(p));
        assign rsp_rdata[p] = rst          ? '0          :
                              rsp_valid[p] ? ram_rd_data : rdata_q;

        always_ff @(posedge clk) begin
            if (rst)
                rdata_q <= '0;
            else if (rsp_valid[p])
                rdata_q <= ram_rd_data;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter with bounded bursts that shares one single-port RAM between
// two requesters. Read data is returned to the issuing port after the RAM latency.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("sp_ram_arbiter: RD_LATENCY must be 1 or 2");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("sp_ram_arbiter: MAX_BURST must be in 1..15");
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    localparam logic [BURST_CNT_W-1:0] MAX_B = BURST_CNT_W'(MAX_BURST);

    req_t [1:0]             req;
    req_t                   sel;
    logic [1:0]             req_valid;
    logic                   gnt_any;
    port_idx_t              gnt_port;
    port_idx_t              owner;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata;

    assign req[0]    = {p0_req_we, p0_req_addr, p0_req_wdata};
    assign req[1]    = {p1_req_we, p1_req_addr, p1_req_wdata};
    assign req_valid = {p1_req_valid, p0_req_valid};

    // Owner keeps the RAM while the other port waits, until its burst is used up.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_port = PORT0;
        if (!rst) begin
            if (req_valid == 2'b11) begin
                gnt_any  = 1'b1;
                gnt_port = (burst_cnt < MAX_B) ? owner : ~owner;
            end else if (req_valid[0]) begin
                gnt_any  = 1'b1;
                gnt_port = PORT0;
            end else if (req_valid[1]) begin
                gnt_any  = 1'b1;
                gnt_port = PORT1;
            end
        end
    end

    assign p0_req_ready = gnt_any & (gnt_port == PORT0);
    assign p1_req_ready = gnt_any & (gnt_port == PORT1);

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= PORT0;
            burst_cnt <= '0;
        end else if (gnt_any) begin
            if (gnt_port == owner) begin
                if (burst_cnt != MAX_B)
                    burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            end else begin
                owner     <= gnt_port;
                burst_cnt <= BURST_CNT_W'(1);
            end
        end
    end

    assign sel         = req[gnt_port];
    assign ram_addr    = gnt_any ? sel.addr  : '0;
    assign ram_wr_data = gnt_any ? sel.wdata : '0;
    assign ram_wr_en   = gnt_any & sel.we;

    sp_ram_arb_rsp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .push_vld    (gnt_any & ~sel.we),
        .push_port   (gnt_port),
        .ram_rd_data (ram_rd_data),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata)
    );

    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_rsp_rdata = rsp_rdata[0];
    assign p1_rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: instance A (RD_LATENCY=1) carries the main
// directed traffic, instance B (RD_LATENCY=2) the reset-with-reads-in-flight case.
module tb_sp_ram_arbiter;
    localparam int AW = 11, DW = 16, MAXB = 4, RDL_A = 1, RDL_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tb_rst, tb_rst_b;

    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic          ram_wr_en;

    logic          b_p0_req_valid, b_p0_req_ready, b_p0_req_we, b_p0_rsp_valid;
    logic [AW-1:0] b_p0_req_addr;
    logic [DW-1:0] b_p0_req_wdata, b_p0_rsp_rdata;
    logic          b_p1_req_valid, b_p1_req_ready, b_p1_req_we, b_p1_rsp_valid;
    logic [AW-1:0] b_p1_req_addr;
    logic [DW-1:0] b_p1_req_wdata, b_p1_rsp_rdata;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_wr_data, b_ram_rd_data;
    logic          b_ram_wr_en;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL_A), .MAX_BURST(MAXB)) u_dut (
        .clk(clk), .rst(tb_rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_data(ram_rd_data)
    );

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL_B), .MAX_BURST(MAXB)) u_dut_b (
        .clk(clk), .rst(tb_rst_b),
        .p0_req_valid(b_p0_req_valid), .p0_req_ready(b_p0_req_ready), .p0_req_we(b_p0_req_we),
        .p0_req_addr(b_p0_req_addr), .p0_req_wdata(b_p0_req_wdata),
        .p0_rsp_valid(b_p0_rsp_valid), .p0_rsp_rdata(b_p0_rsp_rdata),
        .p1_req_valid(b_p1_req_valid), .p1_req_ready(b_p1_req_ready), .p1_req_we(b_p1_req_we),
        .p1_req_addr(b_p1_req_addr), .p1_req_wdata(b_p1_req_wdata),
        .p1_rsp_valid(b_p1_rsp_valid), .p1_rsp_rdata(b_p1_rsp_rdata),
        .ram_addr(b_ram_addr), .ram_wr_data(b_ram_wr_data), .ram_wr_en(b_ram_wr_en),
        .ram_rd_data(b_ram_rd_data)
    );

    // Behavioural RAMs: A has one read stage, B adds an output register.
    logic [DW-1:0] mem_a [0:2047];
    logic [DW-1:0] mem_b [0:2047];
    logic [DW-1:0] rd_a, rd_b1, rd_b2;
    always @(posedge clk) begin
        if (ram_wr_en) mem_a[ram_addr] <= ram_wr_data;
        rd_a <= mem_a[ram_addr];
        if (b_ram_wr_en) mem_b[b_ram_addr] <= b_ram_wr_data;
        rd_b1 <= mem_b[b_ram_addr];
        rd_b2 <= rd_b1;
    end
    assign ram_rd_data   = rd_a;
    assign b_ram_rd_data = rd_b2;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t q0[$], q1[$];
    int   cyc = 0;
    int   tests = 0, fails = 0, b_rsp_cnt = 0;
    logic rdy0_s, rdy1_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops the head of its port's queue and must arrive on time.
    always @(negedge clk) begin
        exp_t e0, e1;
        if (p0_rsp_valid) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL p0_rsp_unexpected: got data %0h, expected no response", p0_rsp_rdata);
            end else begin
                e0 = q0.pop_front();
                chk("p0_rsp_rdata", 32'(p0_rsp_rdata), 32'(e0.data));
                chk("p0_rsp_cycle", cyc, e0.due);
            end
        end
        if (p1_rsp_valid) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL p1_rsp_unexpected: got data %0h, expected no response", p1_rsp_rdata);
            end else begin
                e1 = q1.pop_front();
                chk("p1_rsp_rdata", 32'(p1_rsp_rdata), 32'(e1.data));
                chk("p1_rsp_cycle", cyc, e1.due);
            end
        end
        if (b_p0_rsp_valid || b_p1_rsp_valid) b_rsp_cnt++;
    end

    task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    // One cycle on DUT A: check grant and RAM drive, queue expected read data.
    task automatic cyc_chk(input string name, input logic er0, input logic er1,
                           input logic [DW-1:0] x0, input logic [DW-1:0] x1);
        @(negedge clk);
        chk({name, "_ready0"}, 32'(p0_req_ready), 32'(er0));
        chk({name, "_ready1"}, 32'(p1_req_ready), 32'(er1));
        if (er0) begin
            chk({name, "_ram_addr"}, 32'(ram_addr), 32'(p0_req_addr));
            chk({name, "_ram_wr_en"}, 32'(ram_wr_en), 32'(p0_req_we));
            if (p0_req_we) chk({name, "_ram_wr_data"}, 32'(ram_wr_data), 32'(p0_req_wdata));
        end else if (er1) begin
            chk({name, "_ram_addr"}, 32'(ram_addr), 32'(p1_req_addr));
            chk({name, "_ram_wr_en"}, 32'(ram_wr_en), 32'(p1_req_we));
            if (p1_req_we) chk({name, "_ram_wr_data"}, 32'(ram_wr_data), 32'(p1_req_wdata));
        end else begin
            chk({name, "_ram_wr_en_idle"}, 32'(ram_wr_en), 32'd0);
            chk({name, "_ram_addr_idle"}, 32'(ram_addr), 32'd0);
            chk({name, "_ram_wr_data_idle"}, 32'(ram_wr_data), 32'd0);
        end
        if (er0 && !p0_req_we) q0.push_back('{x0, cyc + RDL_A});
        if (er1 && !p1_req_we) q1.push_back('{x1, cyc + RDL_A});
        rdy0_s = p0_req_ready;
        rdy1_s = p1_req_ready;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, w1, mw;
        logic g0;
        logic [AW-1:0] wa;

        tb_rst = 1'b1; tb_rst_b = 1'b1;
        drv0(1'b1, 1'b1, 11'h005, 16'hAAAA);
        drv1(1'b0, 1'b0, '0, '0);
        {b_p0_req_valid, b_p0_req_we, b_p0_req_addr, b_p0_req_wdata} = '0;
        {b_p1_req_valid, b_p1_req_we, b_p1_req_addr, b_p1_req_wdata} = '0;
        @(posedge clk); #1;
        cyc_chk("in_reset", 1'b0, 1'b0, '0, '0);
        tb_rst = 1'b0; tb_rst_b = 1'b0;
        drv0(1'b0, 1'b0, '0, '0);

        repeat (20) cyc_chk("idle", 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 16; i++) begin
            drv0(1'b1, 1'b1, AW'(i), 16'hFFFF - DW'(i));
            cyc_chk("p0_wr", 1'b1, 1'b0, '0, '0);
        end
        for (int i = 0; i < 16; i++) begin
            drv0(1'b1, 1'b0, AW'(i), '0);
            cyc_chk("p0_rd", 1'b1, 1'b0, 16'hFFFF - DW'(i), '0);
        end
        drv0(1'b0, 1'b0, '0, '0);
        cyc_chk("idle2", 1'b0, 1'b0, '0, '0);

        // Fresh reset so the stream starts from owner = port 0, burst_cnt = 0.
        tb_rst = 1'b1;
        cyc_chk("rst2", 1'b0, 1'b0, '0, '0);
        tb_rst = 1'b0;

        w0 = 0; w1 = 0; mw = 0;
        for (int k = 0; k < 12; k++) begin
            g0 = (k < 4) || (k >= 8);
            drv0(1'b1, 1'b0, AW'(k), '0);
            drv1(1'b1, 1'b0, AW'(15 - k), '0);
            cyc_chk("stream", g0, ~g0, 16'hFFFF - DW'(k), 16'hFFFF - DW'(15 - k));
            w0 = rdy0_s ? 0 : w0 + 1;
            w1 = rdy1_s ? 0 : w1 + 1;
            if (w0 > mw) mw = w0;
            if (w1 > mw) mw = w1;
        end
        chk("stream_max_wait", mw, 4);
        drv0(1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0);

        drv0(1'b1, 1'b1, 11'h7FE, 16'h0BAD);
        cyc_chk("wr_7fe", 1'b1, 1'b0, '0, '0);
        drv0(1'b1, 1'b1, 11'h7FF, 16'h1234);
        cyc_chk("wr_7ff", 1'b1, 1'b0, '0, '0);
        drv0(1'b0, 1'b0, '0, '0);
        drv1(1'b1, 1'b0, 11'h7FF, '0);
        cyc_chk("raw_7ff", 1'b0, 1'b1, '0, 16'h1234);
        wa = 11'h7FF;
        wa = wa + 11'd1;
        drv1(1'b1, 1'b0, wa, '0);
        cyc_chk("wrap_000", 1'b0, 1'b1, '0, 16'hFFFF);
        drv1(1'b1, 1'b0, 11'h7FE, '0);
        cyc_chk("rd_7fe", 1'b0, 1'b1, '0, 16'h0BAD);

        for (int i = 0; i < 10; i++) begin
            drv1(1'b1, 1'b0, 11'h001, '0);
            cyc_chk("p1_alone", 1'b0, 1'b1, '0, 16'hFFFE);
        end
        drv0(1'b1, 1'b0, 11'h002, '0);
        cyc_chk("p0_join", 1'b1, 1'b0, 16'hFFFD, '0);
        cyc_chk("p0_join2", 1'b1, 1'b0, 16'hFFFD, '0);
        drv0(1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0);
        repeat (3) cyc_chk("drain", 1'b0, 1'b0, '0, '0);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        // Instance B: two P1 reads in flight (owner = 1), then a one-cycle reset.
        b_p1_req_valid = 1'b1; b_p1_req_we = 1'b0; b_p1_req_addr = 11'h003;
        @(negedge clk); chk("b_rd1_ready", 32'(b_p1_req_ready), 32'd1);
        @(posedge clk); #1;
        b_p1_req_addr = 11'h004;
        @(negedge clk); chk("b_rd2_ready", 32'(b_p1_req_ready), 32'd1);
        @(posedge clk); #1;
        b_p1_req_valid = 1'b0;
        tb_rst_b = 1'b1;
        @(posedge clk); #1;
        tb_rst_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        b_p0_req_valid = 1'b1; b_p0_req_we = 1'b1; b_p0_req_addr = '0; b_p0_req_wdata = 16'h5555;
        b_p1_req_valid = 1'b1; b_p1_req_we = 1'b1; b_p1_req_addr = '0; b_p1_req_wdata = 16'h6666;
        @(negedge clk);
        chk("b_post_rst_ready0", 32'(b_p0_req_ready), 32'd1);
        chk("b_post_rst_ready1", 32'(b_p1_req_ready), 32'd0);
        @(posedge clk); #1;
        b_p0_req_valid = 1'b0; b_p1_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b_no_rsp_after_rst", b_rsp_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-requester, round-robin arbiter with bounded bursts that shares one single-port RAM (sp_ram_16 class: 11-bit addr, 16-bit data, one clock).
- Accepts read/write requests over valid/ready handshakes and drives the RAM address, data and write enable for the granted requester.
- Returns read data to the issuing requester after the RAM read latency, tagged by port.
- Sits between the line-buffer fill and drain logic and the shared RAM instance.

Parameters:
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- RD_LATENCY, 1, RAM read latency in clk cycles (1 = OUTPUT_REG off, 2 = on); legal values 1..2.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is waiting; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_we  in  1  1 = write, 0 = read
- p0_req_addr  in  ADDR_WIDTH  port 0 address
- p0_req_wdata  in  DATA_WIDTH  port 0 write data
- p0_rsp_valid  out  1  port 0 read data valid (single-cycle pulse)
- p0_rsp_rdata  out  DATA_WIDTH  port 0 read data
- p1_*  (same set as p0_*)  port 1
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_wr_en  out  1  to RAM wr_en
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data

Behaviour:
- Single clock domain. Reset is synchronous, active-high on clk; all state updates on posedge clk.
- Reset values:
  - owner = port 0; burst_cnt = 0.
  - Read-tag pipeline cleared.
  - pX_rsp_valid = 0, pX_rsp_rdata = 0.
  - ram_wr_en = 0 while rst is high; ram_addr and ram_wr_data = 0 while rst is high.
  - pX_req_ready = 0 while rst is high.
- Grant is combinational from the current request valids and the registered (owner, burst_cnt). At most one grant per cycle; pX_req_ready = grant_X.
- Grant rules:
  - Only one port valid: that port is granted.
  - Both valid, burst_cnt < MAX_BURST: owner is granted.
  - Both valid, burst_cnt == MAX_BURST: the non-owner is granted.
  - Neither valid: no grant. ram_wr_en = 0; ram_addr and ram_wr_data hold 0.
- Accept = valid & ready. On accept:
  - Granted port == owner: burst_cnt = burst_cnt + 1, saturating at MAX_BURST.
  - Otherwise: owner = granted port, burst_cnt = 1.
- On an idle cycle, owner and burst_cnt hold.
- RAM drive in the same cycle as accept:
  - ram_addr = granted addr.
  - ram_wr_data = granted wdata.
  - ram_wr_en = granted we.
- Reads:
  - An accepted read pushes {valid = 1, port} into an RD_LATENCY-deep shift register.
  - When the tag exits, on the same edge that ram_rd_data becomes valid (RD_LATENCY cycles after accept), the tagged port's rsp_valid pulses 1 and rsp_rdata takes ram_rd_data.
  - rsp_rdata of the other port holds its previous value.
- Writes produce no response.
- No response backpressure. Requesters must always sink rsp_valid.
- Back-to-back reads are fully pipelined: one response per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data, because the RAM is in NORMAL_WRITE mode and the read is issued after the write.
- A requester may drop valid without an accept. Valid/payload stability is not required; the arbiter samples the payload only in the cycle it is granted.
- Reset mid-burst or with reads in flight: in-flight tags are discarded and no rsp_valid is produced for them. The next grant after reset goes to port 0 if both are valid.
- Throughput: with both ports valid continuously, the grant pattern is MAX_BURST cycles to one port, then MAX_BURST cycles to the other. Starvation is bounded to MAX_BURST cycles.

Decomposition:
- Package sp_ram_arb_pkg holds:
  - port-index type (1 bit);
  - PORT0 and PORT1 constants;
  - burst-counter width constant, $clog2(MAX_BURST+1), max 4.
- Sub-module sp_ram_arb_rsp_pipe: parameterised RD_LATENCY-deep shift register of {valid, port} tags that demultiplexes ram_rd_data into the per-port response registers.
- The top level holds the grant logic, owner/burst state and RAM mux.

Test Plan:
- Reset release, no requests -> ram_wr_en = 0 and all rsp_valid = 0 for 20 cycles; owner = port 0.
- P0 writes addr 0x000..0x00F with data 0xFFFF..0xFFF0, then reads the same range -> 16 reads accepted back-to-back; p0_rsp_valid pulses 1 cycle after each accept (RD_LATENCY = 1) with data 0xFFFF..0xFFF0 in order; p1_rsp_valid stays 0.
- Both ports stream reads continuously with MAX_BURST = 4 -> grant sequence P0×4, P1×4, P0×4; every response is routed to the correct port; no port waits more than 4 cycles.
- P0 writes 0x1234 to addr 0x7FF; the next cycle P1 reads 0x7FF -> p1_rsp_rdata = 0x1234. Also check address wrap at 0x7FF -> 0x000 with no aliasing into other entries.
- Assert rst for 1 cycle while 2 reads are in flight (RD_LATENCY = 2) -> no rsp_valid for those reads; the next request with both ports valid grants port 0.
- P1 alone valid for 10 cycles, then P0 joins -> P1 keeps the grant until burst_cnt reaches MAX_BURST, then P0 is granted in the following cycle.
